// File: rtl/gp_cmd_decoder.sv
// ============================================================================
// Module  : gp_cmd_decoder
// Brief   : Decodes the FIFO_GP command stream into FILL/LINE engine requests.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gp_cmd_decoder #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               GP_valid,
    input  logic [31:0]        fifo_GP_out,
    input  logic               fifo_stall,
    output logic               GP_stall,
    output logic               GP_interrupt,
    output logic               fill_valid,
    input  logic               fill_ready,
    output logic [COLOR_W-1:0] fill_color,
    output logic               line_valid,
    input  logic               line_ready,
    output logic [COLOR_W-1:0] line_color,
    output logic [COORD_W-1:0] line_x0,
    output logic [COORD_W-1:0] line_y0,
    output logic [COORD_W-1:0] line_x1,
    output logic [COORD_W-1:0] line_y1,
    output logic               gp_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DISCARD   = 3'd1,
        S_OPCODE    = 3'd2,
        S_LINE_P0   = 3'd3,
        S_LINE_P1   = 3'd4,
        S_FILL_WAIT = 3'd5,
        S_LINE_WAIT = 3'd6,
        S_STOP      = 3'd7
    } state_e;

    localparam logic [7:0] c_OP_STOP = 8'h00;
    localparam logic [7:0] c_OP_FILL = 8'h01;
    localparam logic [7:0] c_OP_LINE = 8'h02;

    state_e               state_q;
    logic                 fill_valid_q;
    logic                 line_valid_q;
    logic                 irq_q;
    logic [COLOR_W-1:0]   fill_color_q;
    logic [COLOR_W-1:0]   line_color_q;
    logic [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q;

    logic                 w_fetch;
    logic                 w_beat;
    logic [7:0]           w_opcode;
    logic [COORD_W-1:0]   w_pt_x;
    logic [COORD_W-1:0]   w_pt_y;

    // Fetch states are the only ones that pull words from FIFO_GP.
    assign w_fetch  = (state_q == S_DISCARD) || (state_q == S_OPCODE) ||
                      (state_q == S_LINE_P0) || (state_q == S_LINE_P1);
    assign w_beat   = w_fetch && !fifo_stall;
    assign w_opcode = fifo_GP_out[31:24];
    assign w_pt_x   = fifo_GP_out[16 +: COORD_W];
    assign w_pt_y   = fifo_GP_out[0 +: COORD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_valid_q <= 1'b0;
            line_valid_q <= 1'b0;
            irq_q        <= 1'b0;
            fill_color_q <= '0;
            line_color_q <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
        end else if (GP_valid) begin
            // A new list aborts whatever is in flight, including a pending request.
            state_q      <= S_DISCARD;
            fill_valid_q <= 1'b0;
            line_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                S_IDLE: ;
                S_DISCARD: begin
                    if (w_beat) state_q <= S_OPCODE;
                end
                S_OPCODE: begin
                    if (w_beat) begin
                        case (w_opcode)
                            c_OP_FILL: begin
                                fill_color_q <= fifo_GP_out[COLOR_W-1:0];
                                fill_valid_q <= 1'b1;
                                state_q      <= S_FILL_WAIT;
                            end
                            c_OP_LINE: begin
                                line_color_q <= fifo_GP_out[COLOR_W-1:0];
                                state_q      <= S_LINE_P0;
                            end
                            c_OP_STOP: begin
                                irq_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LINE_P0: begin
                    if (w_beat) begin
                        x0_q    <= w_pt_x;
                        y0_q    <= w_pt_y;
                        state_q <= S_LINE_P1;
                    end
                end
                S_LINE_P1: begin
                    if (w_beat) begin
                        x1_q         <= w_pt_x;
                        y1_q         <= w_pt_y;
                        line_valid_q <= 1'b1;
                        state_q      <= S_LINE_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (fill_ready) begin
                        fill_valid_q <= 1'b0;
                        state_q      <= S_OPCODE;
                    end
                end
                S_LINE_WAIT: begin
                    if (line_ready) begin
                        line_valid_q <= 1'b0;
                        state_q      <= S_OPCODE;
                    end
                end
                S_STOP: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign GP_stall     = !w_fetch;
    assign gp_busy      = (state_q != S_IDLE);
    assign GP_interrupt = irq_q;
    assign fill_valid   = fill_valid_q;
    assign fill_color   = fill_color_q;
    assign line_valid   = line_valid_q;
    assign line_color   = line_color_q;
    assign line_x0      = x0_q;
    assign line_y0      = y0_q;
    assign line_x1      = x1_q;
    assign line_y1      = y1_q;

endmodule

`default_nettype wire

// File: tb/tb_gp_cmd_decoder.sv
// ============================================================================
// Module  : tb_gp_cmd_decoder
// Brief   : Scoreboard bench for gp_cmd_decoder with directed command lists.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gp_cmd_decoder;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 24;
    localparam int K_FILL = 1;
    localparam int K_LINE = 2;
    localparam int K_IRQ  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               GP_valid;
    logic [31:0]        fifo_GP_out;
    logic               fifo_stall;
    logic               GP_stall;
    logic               GP_interrupt;
    logic               fill_valid;
    logic               fill_ready;
    logic [COLOR_W-1:0] fill_color;
    logic               line_valid;
    logic               line_ready;
    logic [COLOR_W-1:0] line_color;
    logic [COORD_W-1:0] line_x0, line_y0, line_x1, line_y1;
    logic               gp_busy;

    typedef struct {
        int                 kind;
        logic [COLOR_W-1:0] color;
        logic [4*COORD_W-1:0] pts;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    gp_cmd_decoder #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .GP_valid     (GP_valid),
        .fifo_GP_out  (fifo_GP_out),
        .fifo_stall   (fifo_stall),
        .GP_stall     (GP_stall),
        .GP_interrupt (GP_interrupt),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_color   (fill_color),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .line_color   (line_color),
        .line_x0      (line_x0),
        .line_y0      (line_y0),
        .line_x1      (line_x1),
        .line_y1      (line_y1),
        .gp_busy      (gp_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_fill(input logic [23:0] c);
        exp_t e;
        e.kind = K_FILL; e.color = c; e.pts = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_line(input logic [23:0] c, input int x0, input int y0, input int x1, input int y1);
        exp_t e;
        e.kind  = K_LINE; e.color = c;
        e.pts   = {x0[9:0], y0[9:0], x1[9:0], y1[9:0]};
        exp_q.push_back(e);
    endtask

    task automatic push_irq();
        exp_t e;
        e.kind = K_IRQ; e.color = '0; e.pts = '0;
        exp_q.push_back(e);
    endtask

    // Presents one word as the FIFO head (after nstall stalled cycles with junk) until consumed.
    task automatic send(input logic [31:0] w, input int nstall);
        int n;
        for (int i = 0; i < nstall; i++) begin
            fifo_GP_out = 32'hFFFF_FFFF;
            fifo_stall  = 1'b1;
            @(negedge clk);
        end
        fifo_GP_out = w;
        fifo_stall  = 1'b0;
        n = 0;
        while (GP_stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: word %h never consumed", w);
        end
        @(posedge clk);
        @(negedge clk);
        fifo_stall  = 1'b1;
        fifo_GP_out = 32'hFFFF_FFFF;
    endtask

    task automatic pulse_gpv();
        GP_valid = 1'b1;
        @(negedge clk);
        GP_valid = 1'b0;
    endtask

    // Monitor: pops on every transfer/interrupt, and checks payload stability while stalled.
    initial begin : monitor
        logic                 p_fhold, p_lhold, p_irq;
        logic [COLOR_W-1:0]   p_fcol, p_lcol;
        logic [4*COORD_W-1:0] p_pts;
        exp_t e;
        p_fhold = 1'b0; p_lhold = 1'b0; p_irq = 1'b0;
        p_fcol = '0; p_lcol = '0; p_pts = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (fill_valid && line_valid)
                    chk("both_valid", 64'(fill_valid & line_valid), 64'd0);
                if (p_fhold)
                    chk("fill_hold", {39'd0, fill_valid, fill_color}, {39'd1, p_fcol});
                if (p_lhold)
                    chk("line_hold", {line_valid, line_color, line_x0, line_y0, line_x1, line_y1},
                                     {1'b1, p_lcol, p_pts});
                if (p_irq)
                    chk("irq_width", 64'(GP_interrupt), 64'd0);
                if ((fill_valid && fill_ready && !GP_valid) ||
                    (line_valid && line_ready && !GP_valid) || GP_interrupt) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: fv=%b lv=%b irq=%b", fill_valid, line_valid, GP_interrupt);
                    end else begin
                        e = exp_q.pop_front();
                        if (GP_interrupt) begin
                            chk("irq_kind", 64'(K_IRQ), 64'(e.kind));
                        end else if (fill_valid) begin
                            chk("fill_kind", 64'(K_FILL), 64'(e.kind));
                            chk("fill_color", 64'(fill_color), 64'(e.color));
                        end else begin
                            chk("line_kind", 64'(K_LINE), 64'(e.kind));
                            chk("line_color", 64'(line_color), 64'(e.color));
                            chk("line_pts", 64'({line_x0, line_y0, line_x1, line_y1}), 64'(e.pts));
                        end
                    end
                end
            end
            p_fhold = fill_valid && !fill_ready && !GP_valid && !rst;
            p_lhold = line_valid && !line_ready && !GP_valid && !rst;
            p_irq   = GP_interrupt && !rst;
            p_fcol  = fill_color;
            p_lcol  = line_color;
            p_pts   = {line_x0, line_y0, line_x1, line_y1};
        end
    end

    initial begin : stim
        int n;
        rst = 1'b1; GP_valid = 1'b0; fifo_GP_out = 32'hFFFF_FFFF; fifo_stall = 1'b1;
        fill_ready = 1'b0; line_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_GP_stall",     64'(GP_stall), 64'd1);
        chk("rst_fill_valid",   64'(fill_valid), 64'd0);
        chk("rst_line_valid",   64'(line_valid), 64'd0);
        chk("rst_GP_interrupt", 64'(GP_interrupt), 64'd0);
        chk("rst_gp_busy",      64'(gp_busy), 64'd0);

        // FILL, then an unknown opcode skipped, then a second FILL
        fill_ready = 1'b1;
        pulse_gpv();
        chk("discard_busy", 64'(gp_busy), 64'd1);
        send(32'hDEAD_BEEF, 0);
        push_fill(24'hFF0000);
        send(32'h01FF_0000, 0);
        send(32'h7F12_3456, 0);
        push_fill(24'hABCDEF);
        send(32'h01AB_CDEF, 0);

        // LINE held off by the engine for 5 cycles
        push_line(24'h00FF00, 5, 7, 799, 479);
        send(32'h0200_FF00, 0);
        send(32'h0005_0007, 0);
        send(32'h031F_01DF, 0);
        for (int i = 0; i < 5; i++) begin
            chk("line_wait_valid", 64'(line_valid), 64'd1);
            chk("line_wait_stall", 64'(GP_stall), 64'd1);
            @(negedge clk);
        end
        line_ready = 1'b1;
        n = 0;
        while (line_valid && n < 20) begin @(negedge clk); n++; end
        chk("line_drop", 64'(line_valid), 64'd0);

        // LINE with FIFO stalls between words; junk on the bus must not be taken
        push_line(24'h123456, 1023, 0, 0, 1023);
        send(32'h0212_3456, 3);
        send(32'h03FF_0000, 2);
        send(32'h0000_03FF, 4);

        // STOP
        push_irq();
        send(32'h0000_0000, 1);
        @(negedge clk);
        @(negedge clk);
        chk("stop_idle_busy",  64'(gp_busy), 64'd0);
        chk("stop_idle_stall", 64'(GP_stall), 64'd1);

        // Abort during LINE_P1
        pulse_gpv();
        send(32'h1234_5678, 0);
        send(32'h02AA_AAAA, 0);
        send(32'h0001_0002, 0);
        pulse_gpv();
        chk("abort_p1_lvalid", 64'(line_valid), 64'd0);
        chk("abort_p1_stall",  64'(GP_stall), 64'd0);

        // Abort during FILL_WAIT
        fill_ready = 1'b0;
        send(32'h1111_1111, 0);
        send(32'h0111_2233, 0);
        @(negedge clk);
        chk("fill_wait_valid", 64'(fill_valid), 64'd1);
        pulse_gpv();
        chk("abort_fw_fvalid", 64'(fill_valid), 64'd0);
        chk("abort_fw_stall",  64'(GP_stall), 64'd0);
        chk("abort_fw_busy",   64'(gp_busy), 64'd1);

        // Fresh list decodes normally after the abort
        fill_ready = 1'b1;
        send(32'h2222_2222, 0);
        push_line(24'h445566, 100, 50, 200, 150);
        send(32'h0244_5566, 0);
        send(32'h0064_0032, 0);
        send(32'h00C8_0096, 0);
        push_irq();
        send(32'h0000_0000, 0);
        repeat (4) @(negedge clk);
        chk("final_idle", 64'(gp_busy), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
